// File: rtl/cdb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_pkg
//  Description : Shared common-data-bus definitions. Reservation stations and
//                the register status table import this package to decode the
//                CDB broadcast.
//  Contents    : CDB_TAG_W, CDB_DATA_W - default tag / data widths
//                cdb_bus_t             - one CDB broadcast {valid, tag, data}
//  Revision    : 1.0 - initial release
// ============================================================================
package cdb_pkg;

   localparam int CDB_TAG_W  = 6;
   localparam int CDB_DATA_W = 32;

   typedef struct packed {
      logic                  valid;
      logic [CDB_TAG_W-1:0]  tag;
      logic [CDB_DATA_W-1:0] data;
   } cdb_bus_t;

endpackage : cdb_pkg
`default_nettype wire

// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter_if
//  Description : Execution-unit result handshake and CDB broadcast bundle.
//  Signals     : req_valid/req_tag/req_data - per-unit result offer (packed)
//                req_ready                  - per-unit accept
//                cdb_valid/tag/data/src     - registered CDB broadcast
//  Modports    : master - execution-unit side (drives requests, snoops CDB)
//                slave  - arbiter side
//  Revision    : 1.0 - initial release
// ============================================================================
interface cdb_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int TAG_W  = 6,
   parameter int DATA_W = 32
);
   localparam int SRC_W = $clog2(N_REQ);

   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*TAG_W-1:0]  req_tag;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_ready;
   logic                    cdb_valid;
   logic [TAG_W-1:0]        cdb_tag;
   logic [DATA_W-1:0]       cdb_data;
   logic [SRC_W-1:0]        cdb_src;

   modport master (
      output req_valid, req_tag, req_data,
      input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
   );

   modport slave (
      input  req_valid, req_tag, req_data,
      output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
   );

endinterface : cdb_arbiter_if
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Searches upward from ptr
//                with wrap-around; the first asserted request wins.
//  Ports       : req       - request vector
//                ptr       - highest-priority index this cycle
//                grant     - one-hot grant (all-zero when no request)
//                grant_idx - encoded grant index (0 when no request)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter int N = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx
);

   always_comb begin
      logic        w_found;
      int unsigned w_idx;
      grant     = '0;
      grant_idx = '0;
      w_found   = 1'b0;
      w_idx     = 0;
      for (int k = 0; k < N; k++) begin
         w_idx = (int'(ptr) + k) % N;
         if (!w_found && req[w_idx]) begin
            grant[w_idx] = 1'b1;
            grant_idx    = IDX_W'(w_idx);
            w_found      = 1'b1;
         end
      end
   end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter
//  Description : Common data bus arbiter. Each execution unit owns a one-entry
//                result buffer; one buffered result per cycle is granted in
//                round-robin order and broadcast on the registered CDB.
//  Ports       : i_clk   - clock
//                i_rst_n - asynchronous active-low reset
//                flush   - synchronous pipeline flush, dominates everything
//                bus     - cdb_arbiter_if.slave (requests + CDB broadcast)
//  Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int TAG_W  = CDB_TAG_W,
   parameter int DATA_W = CDB_DATA_W
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          flush,
   cdb_arbiter_if.slave  bus
);

   localparam int SRC_W = $clog2(N_REQ);

   logic [N_REQ-1:0]  r_buf_valid;
   logic [TAG_W-1:0]  r_buf_tag  [N_REQ];
   logic [DATA_W-1:0] r_buf_data [N_REQ];
   logic [SRC_W-1:0]  r_rr_ptr;

   logic              r_cdb_valid;
   logic [TAG_W-1:0]  r_cdb_tag;
   logic [DATA_W-1:0] r_cdb_data;
   logic [SRC_W-1:0]  r_cdb_src;

   logic [N_REQ-1:0]  w_grant;
   logic [SRC_W-1:0]  w_grant_idx;
   logic              w_grant_any;
   logic [N_REQ-1:0]  w_accept;
   logic [SRC_W-1:0]  w_ptr_next;

   rr_arbiter #(
      .N     (N_REQ),
      .IDX_W (SRC_W)
   ) u_rr_arbiter (
      .req       (r_buf_valid),
      .ptr       (r_rr_ptr),
      .grant     (w_grant),
      .grant_idx (w_grant_idx)
   );

   assign w_grant_any = |w_grant;

   // A buffer being granted this cycle frees up, so it can take a new
   // result in the same cycle (sustained one-per-cycle for a lone winner).
   assign bus.req_ready = {N_REQ{~flush}} & (~r_buf_valid | w_grant);
   assign w_accept      = bus.req_valid & bus.req_ready;

   assign w_ptr_next = (w_grant_idx == SRC_W'(N_REQ - 1)) ? '0
                                                           : w_grant_idx + SRC_W'(1);

   // Per-unit result buffers; an accept overrides the clear from a grant.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_buf_valid <= '0;
         for (int i = 0; i < N_REQ; i++) begin
            r_buf_tag[i]  <= '0;
            r_buf_data[i] <= '0;
         end
      end else if (flush) begin
         r_buf_valid <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (w_accept[i]) begin
               r_buf_valid[i] <= 1'b1;
               r_buf_tag[i]   <= bus.req_tag[i*TAG_W +: TAG_W];
               r_buf_data[i]  <= bus.req_data[i*DATA_W +: DATA_W];
            end else if (w_grant[i]) begin
               r_buf_valid[i] <= 1'b0;
            end
         end
      end
   end

   // CDB output registers and round-robin pointer. cdb_src keeps the last
   // winner when idle and is not touched by flush.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cdb_valid <= 1'b0;
         r_cdb_tag   <= '0;
         r_cdb_data  <= '0;
         r_cdb_src   <= '0;
         r_rr_ptr    <= '0;
      end else if (flush) begin
         r_cdb_valid <= 1'b0;
         r_cdb_tag   <= '0;
         r_cdb_data  <= '0;
         r_rr_ptr    <= '0;
      end else if (w_grant_any) begin
         r_cdb_valid <= 1'b1;
         r_cdb_tag   <= r_buf_tag[w_grant_idx];
         r_cdb_data  <= r_buf_data[w_grant_idx];
         r_cdb_src   <= w_grant_idx;
         r_rr_ptr    <= w_ptr_next;
      end else begin
         r_cdb_valid <= 1'b0;
         r_cdb_tag   <= '0;
         r_cdb_data  <= '0;
      end
   end

   assign bus.cdb_valid = r_cdb_valid;
   assign bus.cdb_tag   = r_cdb_tag;
   assign bus.cdb_data  = r_cdb_data;
   assign bus.cdb_src   = r_cdb_src;

endmodule : cdb_arbiter
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdb_arbiter
//  Description : Self-checking bench for cdb_arbiter. Results accepted by the
//                arbiter are pushed to a scoreboard in expected broadcast
//                order and popped when the CDB shows a broadcast.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

   localparam int N  = 4;
   localparam int TW = 6;
   localparam int DW = 32;
   localparam int SW = 2;

   typedef struct packed {
      logic [TW-1:0] tag;
      logic [DW-1:0] data;
      logic [SW-1:0] src;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic flush;

   cdb_arbiter_if #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW)) bus ();

   cdb_arbiter #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .flush   (flush),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   exp_t          sb[$];
   logic [TW-1:0] u_tag[N][$];
   logic [DW-1:0] u_data[N][$];
   int            checks = 0;
   int            errors = 0;
   int            bcasts = 0;
   logic          sb_en;
   logic [N-1:0]  cyc_ready;

   function automatic bit units_pending();
      bit p = 1'b0;
      for (int i = 0; i < N; i++) if (u_tag[i].size() > 0) p = 1'b1;
      return p;
   endfunction

   // One clock cycle: present requests, record accepts, then sample the CDB.
   task automatic cycle();
      exp_t e;
      exp_t got;
      for (int i = 0; i < N; i++) begin
         if (u_tag[i].size() > 0) begin
            bus.req_valid[i]            = 1'b1;
            bus.req_tag[i*TW +: TW]     = u_tag[i][0];
            bus.req_data[i*DW +: DW]    = u_data[i][0];
         end else begin
            bus.req_valid[i]            = 1'b0;
         end
      end
      #1;
      cyc_ready = bus.req_ready;
      for (int i = 0; i < N; i++) begin
         if (bus.req_valid[i] && bus.req_ready[i]) begin
            if (sb_en) begin
               e.tag  = u_tag[i][0];
               e.data = u_data[i][0];
               e.src  = SW'(i);
               sb.push_back(e);
            end
            void'(u_tag[i].pop_front());
            void'(u_data[i].pop_front());
         end
      end
      @(negedge clk);
      checks++;
      if (bus.cdb_valid) begin
         bcasts++;
         got = {bus.cdb_tag, bus.cdb_data, bus.cdb_src};
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL cdb_unexpected: got tag=%h data=%h src=%0d, expected no broadcast",
                     bus.cdb_tag, bus.cdb_data, bus.cdb_src);
         end else begin
            e = sb.pop_front();
            if (got !== e) begin
               errors++;
               $display("FAIL cdb_broadcast: got tag=%h data=%h src=%0d, expected tag=%h data=%h src=%0d",
                        got.tag, got.data, got.src, e.tag, e.data, e.src);
            end
         end
      end else if (bus.cdb_tag !== '0 || bus.cdb_data !== '0) begin
         errors++;
         $display("FAIL cdb_idle_zero: got tag=%h data=%h, expected 0 0", bus.cdb_tag, bus.cdb_data);
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((sb.size() > 0 || units_pending()) && n < 40) begin
         cycle();
         n++;
      end
      repeat (2) cycle();
      checks++;
      if (sb.size() != 0 || units_pending()) begin
         errors++;
         $display("FAIL %s_timeout: got %0d results outstanding, expected 0", name, sb.size());
      end
   endtask

   task automatic do_flush();
      flush = 1'b1;
      cycle();
      flush = 1'b0;
   endtask

   task automatic add(input int u, input logic [TW-1:0] t, input logic [DW-1:0] d);
      u_tag[u].push_back(t);
      u_data[u].push_back(d);
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (bus.req_ready !== 4'b1111 || bus.cdb_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got ready=%b cdb_valid=%b, expected 1111 0", bus.req_ready, bus.cdb_valid);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         cycle();
         checks++;
         if (bus.cdb_valid !== 1'b0 || cyc_ready !== 4'b1111) begin
            errors++;
            $display("FAIL reset_idle: got cdb_valid=%b ready=%b, expected 0 1111", bus.cdb_valid, cyc_ready);
         end
      end
   endtask

   task automatic test_single();
      add(2, 6'h05, 32'hDEAD_BEEF);
      cycle();
      checks++;
      if (bus.cdb_valid !== 1'b0) begin
         errors++; $display("FAIL single_c1: got cdb_valid=%b, expected 0", bus.cdb_valid);
      end
      cycle();
      checks++;
      if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'd2) begin
         errors++; $display("FAIL single_c2: got valid=%b src=%0d, expected 1 2", bus.cdb_valid, bus.cdb_src);
      end
      cycle();
      checks++;
      if (bus.cdb_valid !== 1'b0) begin
         errors++; $display("FAIL single_c3: got cdb_valid=%b, expected 0", bus.cdb_valid);
      end
      drain("single");
   endtask

   task automatic test_all_four();
      do_flush();
      for (int i = 0; i < N; i++) add(i, TW'(i + 1), 32'hA000_0000 + DW'(i));
      cycle();
      cycle();
      checks++;
      if (cyc_ready[3:1] !== 3'b000) begin
         errors++; $display("FAIL all4_ready: got ready[3:1]=%b, expected 000", cyc_ready[3:1]);
      end
      for (int c = 0; c < 3; c++) begin
         cycle();
         checks++;
         if (bus.cdb_valid !== 1'b1) begin
            errors++; $display("FAIL all4_b2b: got cdb_valid=%b at step %0d, expected 1", bus.cdb_valid, c);
         end
      end
      drain("all4");
   endtask

   task automatic test_fairness();
      int b0;
      do_flush();
      b0 = bcasts;
      for (int k = 0; k < 8; k++) begin
         add(0, 6'h10 + TW'(k), 32'h0000_1000 + DW'(k));
         add(3, 6'h20 + TW'(k), 32'h0000_3000 + DW'(k));
      end
      for (int c = 0; c < 17; c++) cycle();
      checks++;
      if (bcasts - b0 != 16) begin
         errors++; $display("FAIL fair_rate: got %0d broadcasts in 17 cycles, expected 16", bcasts - b0);
      end
      drain("fair");
   endtask

   task automatic test_refill();
      int b0;
      do_flush();
      b0 = bcasts;
      for (int k = 0; k < 6; k++) add(1, 6'h30 + TW'(k), 32'h5555_0000 + DW'(k));
      for (int c = 1; c <= 7; c++) begin
         cycle();
         if (c <= 6) begin
            checks++;
            if (cyc_ready[1] !== 1'b1) begin
               errors++; $display("FAIL refill_ready: got req_ready[1]=%b cycle %0d, expected 1", cyc_ready[1], c);
            end
         end
         if (c >= 2) begin
            checks++;
            if (bus.cdb_valid !== 1'b1) begin
               errors++; $display("FAIL refill_rate: got cdb_valid=%b cycle %0d, expected 1", bus.cdb_valid, c);
            end
         end
      end
      checks++;
      if (bcasts - b0 != 6) begin
         errors++; $display("FAIL refill_count: got %0d broadcasts, expected 6", bcasts - b0);
      end
      drain("refill");
   endtask

   task automatic test_flush();
      do_flush();
      sb_en = 1'b0;
      add(0, 6'h3A, 32'hBAD0_0000);
      add(1, 6'h3B, 32'hBAD0_0001);
      add(2, 6'h3C, 32'hBAD0_0002);
      cycle();
      add(3, 6'h3F, 32'hBAD0_0003);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      checks++;
      if (cyc_ready !== 4'b0000) begin
         errors++; $display("FAIL flush_ready: got ready=%b during flush, expected 0000", cyc_ready);
      end
      checks++;
      if (bus.cdb_valid !== 1'b0) begin
         errors++; $display("FAIL flush_cdb: got cdb_valid=%b, expected 0", bus.cdb_valid);
      end
      u_tag[3].delete();
      u_data[3].delete();
      sb_en = 1'b1;
      cycle();
      checks++;
      if (cyc_ready !== 4'b1111) begin
         errors++; $display("FAIL flush_empty: got ready=%b, expected 1111", cyc_ready);
      end
      // Pointer back at 0: unit 0 must beat unit 3.
      add(3, 6'h07, 32'h0000_0777);
      add(0, 6'h06, 32'h0000_0666);
      drain("flush");
   endtask

   task automatic test_async_reset();
      sb_en = 1'b0;
      add(0, 6'h2E, 32'hFEED_0000);
      cycle();
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.cdb_valid !== 1'b0 || bus.req_ready !== 4'b1111 || bus.cdb_src !== 2'd0) begin
         errors++;
         $display("FAIL async_reset: got valid=%b ready=%b src=%0d, expected 0 1111 0",
                  bus.cdb_valid, bus.req_ready, bus.cdb_src);
      end
      @(negedge clk);
      rst_n = 1'b1;
      sb_en = 1'b1;
      drain("async_reset");
   endtask

   initial begin
      rst_n         = 1'b0;
      flush         = 1'b0;
      sb_en         = 1'b1;
      bus.req_valid = '0;
      bus.req_tag   = '0;
      bus.req_data  = '0;
      test_reset();
      test_single();
      test_all_four();
      test_fairness();
      test_refill();
      test_flush();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_cdb_arbiter
`default_nettype wire
